// File: rtl/spark_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : spark_pwm_multi
//  Purpose  : Multi-channel servo-style PWM generator. One free-running frame
//             counter feeds NUM_CH channels; each channel turns a signed
//             speed (direction + magnitude) into a high time around CENTER.
//             It captures updates and applies ramping only at frame
//             boundaries, and enables/disables on frame edges.
//  Revision : 1.0 - initial release
// ============================================================================
module spark_pwm_multi #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 12,
    parameter int RATIO_W   = 8,
    parameter int CENTER    = 635,
    parameter int RAMP_STEP = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          pwm_enable,
    input  logic [NUM_CH*RATIO_W-1:0]  pwm_ratio,
    input  logic [NUM_CH-1:0]          pwm_direction,
    input  logic [NUM_CH-1:0]          pwm_update,
    output logic [NUM_CH-1:0]          pwm_done,
    output logic [NUM_CH-1:0]          pwm_settled,
    output logic [NUM_CH-1:0]          pwm_signal
);

    localparam logic [CNT_W-1:0] c_CENTER = CNT_W'(CENTER);
    localparam logic [CNT_W-1:0] c_STEP   = CNT_W'(RAMP_STEP);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    logic [CNT_W-1:0] r_cnt;
    logic             w_boundary;

    // Shared frame counter: free-running, wraps naturally at 2^CNT_W.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_boundary = (r_cnt == '0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_e        r_state;
        ch_state_e        w_state_nxt;
        logic [CNT_W-1:0] r_cur;
        logic [CNT_W-1:0] r_tgt;
        logic [CNT_W-1:0] w_cur_nxt;
        logic [CNT_W-1:0] w_tgt_nxt;
        logic [CNT_W-1:0] w_ratio;
        logic [CNT_W-1:0] w_req;
        logic [CNT_W-1:0] w_diff;
        logic             w_up;
        logic             w_done_nxt;
        logic             r_done;
        logic             r_settled;
        logic             r_signal;

        // Requested high time; parameter limits guarantee no wrap either way.
        assign w_ratio = {{(CNT_W-RATIO_W){1'b0}}, pwm_ratio[i*RATIO_W +: RATIO_W]};
        assign w_req   = pwm_direction[i] ? (c_CENTER + w_ratio) : (c_CENTER - w_ratio);

        // Ramp direction and remaining distance toward the old target.
        assign w_up    = (r_cur < r_tgt);
        assign w_diff  = w_up ? (r_tgt - r_cur) : (r_cur - r_tgt);

        // Frame-boundary state transition, capture and ramp step.
        always_comb begin
            w_state_nxt = r_state;
            w_cur_nxt   = r_cur;
            w_tgt_nxt   = r_tgt;
            w_done_nxt  = 1'b0;
            if (w_boundary) begin
                if (r_state == ST_IDLE) begin
                    if (pwm_enable[i]) begin
                        w_state_nxt = ST_RUN;
                        w_cur_nxt   = c_CENTER;
                        w_tgt_nxt   = pwm_update[i] ? w_req : c_CENTER;
                        w_done_nxt  = pwm_update[i];
                    end
                end else begin
                    if (!pwm_enable[i]) begin
                        w_state_nxt = ST_IDLE;
                        w_cur_nxt   = c_CENTER;
                        w_tgt_nxt   = c_CENTER;
                    end else begin
                        if (pwm_update[i]) begin
                            w_tgt_nxt  = w_req;
                            w_done_nxt = 1'b1;
                        end
                        // Ramp chases the pre-capture target; a fresh target
                        // only steers the ramp from the next boundary on.
                        if (RAMP_STEP == 0) begin
                            w_cur_nxt = w_tgt_nxt;
                        end else if (w_diff > c_STEP) begin
                            w_cur_nxt = w_up ? (r_cur + c_STEP) : (r_cur - c_STEP);
                        end else begin
                            w_cur_nxt = r_tgt;
                        end
                    end
                end
            end
        end

        // Channel registers; the output compare uses pre-edge state and count.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_state   <= ST_IDLE;
                r_cur     <= c_CENTER;
                r_tgt     <= c_CENTER;
                r_done    <= 1'b0;
                r_settled <= 1'b0;
                r_signal  <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cur     <= w_cur_nxt;
                r_tgt     <= w_tgt_nxt;
                r_done    <= w_done_nxt;
                r_settled <= (w_state_nxt == ST_RUN) && (w_cur_nxt == w_tgt_nxt);
                r_signal  <= (r_state == ST_RUN) && (r_cnt < r_cur);
            end
        end

        assign pwm_done[i]    = r_done;
        assign pwm_settled[i] = r_settled;
        assign pwm_signal[i]  = r_signal;
    end

endmodule
`default_nettype wire

// File: tb/tb_spark_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spark_pwm_multi
//  Purpose  : Randomized self-checking bench for spark_pwm_multi. Two DUTs
//             (ramped and jump) share stimulus and are compared every cycle
//             against a frame-rule reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spark_pwm_multi;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 12;
    localparam int RATIO_W = 8;
    localparam int CENTER  = 635;
    localparam int FRAME   = 1 << CNT_W;
    localparam int NCYC    = 20 * FRAME + 50;
    localparam int RST_CYC = 10 * FRAME + 1234;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_CH-1:0]         en;
    logic [NUM_CH-1:0]         dir;
    logic [NUM_CH-1:0]         upd;
    logic [NUM_CH*RATIO_W-1:0] ratio;
    logic [NUM_CH-1:0]         done_a, set_a, sig_a;
    logic [NUM_CH-1:0]         done_b, set_b, sig_b;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: index 0 = RAMP_STEP 4 device, 1 = RAMP_STEP 0.
    int          m_cnt;
    int          m_run [2][NUM_CH];
    int          m_cur [2][NUM_CH];
    int          m_tgt [2][NUM_CH];
    logic [NUM_CH-1:0] e_sig [2];
    logic [NUM_CH-1:0] e_done[2];
    logic [NUM_CH-1:0] e_set [2];

    always #5 clock = ~clock;

    spark_pwm_multi #(.RAMP_STEP(4)) u_dut_ramp (
        .clock(clock), .reset(reset), .pwm_enable(en), .pwm_ratio(ratio),
        .pwm_direction(dir), .pwm_update(upd),
        .pwm_done(done_a), .pwm_settled(set_a), .pwm_signal(sig_a)
    );

    spark_pwm_multi #(.RAMP_STEP(0)) u_dut_jump (
        .clock(clock), .reset(reset), .pwm_enable(en), .pwm_ratio(ratio),
        .pwm_direction(dir), .pwm_update(upd),
        .pwm_done(done_b), .pwm_settled(set_b), .pwm_signal(sig_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int step_of(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    // One clock of the frame rules, using the inputs present before the edge.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                int r;
                int req;
                int old;
                int gap;
                if (reset) begin
                    m_run[d][c] = 0;
                    m_cur[d][c] = CENTER;
                    m_tgt[d][c] = CENTER;
                    e_sig[d][c] = 1'b0;
                    e_done[d][c] = 1'b0;
                    e_set[d][c] = 1'b0;
                end else begin
                    e_sig[d][c]  = (m_run[d][c] != 0) && (m_cnt < m_cur[d][c]);
                    e_done[d][c] = 1'b0;
                    if (m_cnt == 0) begin
                        r   = int'(ratio[c*RATIO_W +: RATIO_W]);
                        req = dir[c] ? CENTER + r : CENTER - r;
                        if (m_run[d][c] == 0) begin
                            if (en[c]) begin
                                m_run[d][c]  = 1;
                                m_cur[d][c]  = CENTER;
                                m_tgt[d][c]  = upd[c] ? req : CENTER;
                                e_done[d][c] = upd[c];
                            end
                        end else if (!en[c]) begin
                            m_run[d][c] = 0;
                            m_cur[d][c] = CENTER;
                            m_tgt[d][c] = CENTER;
                        end else begin
                            old = m_tgt[d][c];
                            if (upd[c]) begin
                                m_tgt[d][c]  = req;
                                e_done[d][c] = 1'b1;
                            end
                            if (step_of(d) == 0) begin
                                m_cur[d][c] = m_tgt[d][c];
                            end else begin
                                gap = old - m_cur[d][c];
                                if (gap > step_of(d))       gap = step_of(d);
                                else if (gap < -step_of(d)) gap = -step_of(d);
                                m_cur[d][c] = m_cur[d][c] + gap;
                            end
                        end
                    end
                    e_set[d][c] = (m_run[d][c] != 0) && (m_cur[d][c] == m_tgt[d][c]);
                end
            end
        end
        m_cnt = reset ? 0 : (m_cnt + 1) % FRAME;
    endtask

    task automatic randomize_frame();
        for (int c = 0; c < NUM_CH; c++) begin
            int pick;
            en[c]  = ($urandom_range(0, 4) != 0);
            dir[c] = $urandom_range(0, 1);
            upd[c] = ($urandom_range(0, 2) == 0);
            pick   = $urandom_range(0, 3);
            if (pick == 0)      ratio[c*RATIO_W +: RATIO_W] = '0;
            else if (pick == 1) ratio[c*RATIO_W +: RATIO_W] = '1;
            else                ratio[c*RATIO_W +: RATIO_W] = RATIO_W'($urandom);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 4'b0001;
        dir   = '0;
        upd   = '0;
        ratio = '0;
        m_cnt = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clock);
            model_step();
            #1;
            check_val("ramp_signal",  32'(sig_a),  32'(e_sig[0]));
            check_val("ramp_done",    32'(done_a), 32'(e_done[0]));
            check_val("ramp_settled", 32'(set_a),  32'(e_set[0]));
            check_val("jump_signal",  32'(sig_b),  32'(e_sig[1]));
            check_val("jump_done",    32'(done_b), 32'(e_done[1]));
            check_val("jump_settled", 32'(set_b),  32'(e_set[1]));

            // Next-cycle stimulus.
            reset = (cyc < 1) || (cyc == RST_CYC);
            for (int c = 0; c < NUM_CH; c++) begin
                if (e_done[0][c]) upd[c] = 1'b0;
            end
            if (cyc > FRAME && m_cnt == 3000) begin
                randomize_frame();
            end
            if (m_cnt == 1000 && $urandom_range(0, 2) == 0) begin
                en[$urandom_range(0, NUM_CH-1)] = 1'b0;
            end
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spark_pwm_multi.md
# spark_pwm_multi

Multi-channel, parametrised successor to the single-channel SparkMax PWM generator. One shared frame counter drives NUM_CH independent PWM outputs. Each output encodes a signed speed as a high time around a neutral centre. Each channel has per-frame update capture, optional slew-rate ramping of the high time, and clean frame-aligned enable/disable. It sits between the register/command layer and the motor-controller PWM pins.

## Interface
- NUM_CH, 4, number of independent PWM channels
- CNT_W, 12, frame counter width; frame = 2^CNT_W clock cycles
- RATIO_W, 8, width of each channel's magnitude input
- CENTER, 635, neutral high time in cycles; must satisfy CENTER >= 2^RATIO_W-1 and CENTER+2^RATIO_W-1 < 2^CNT_W
- RAMP_STEP, 4, max change of applied high time per frame in cycles; 0 = no ramp (jump)

- clock  in  1  main clock
- reset  in  1  synchronous, active-high reset
- pwm_enable  in  NUM_CH  per-channel enable (level)
- pwm_ratio  in  NUM_CH*RATIO_W  per-channel magnitude; channel i at [i*RATIO_W +: RATIO_W]
- pwm_direction  in  NUM_CH  1 = forward (CENTER+ratio), 0 = reverse (CENTER-ratio)
- pwm_update  in  NUM_CH  per-channel update request (level, held until done)
- pwm_done  out  NUM_CH  one-cycle pulse: request captured
- pwm_settled  out  NUM_CH  level: channel RUN and applied high time == target
- pwm_signal  out  NUM_CH  PWM waveforms

## Operation
- Shared counter cnt: CNT_W bits, increments every cycle from reset, wraps 2^CNT_W-1 -> 0. It never stops.
- Frame boundary: the cycle where cnt == 0. All channel state changes happen only on the edge that ends a boundary cycle.
- Per channel i: state IDLE/RUN, cur (applied high time, CNT_W), tgt (target, CNT_W).
- req_i = pwm_direction ? CENTER + pwm_ratio : CENTER - pwm_ratio, zero-extended to CNT_W. There is no overflow by parameter constraint.
- At boundary, per channel, evaluated from pre-edge values:
  - IDLE, enable=0: stay IDLE; update ignored, no done.
  - IDLE, enable=1: -> RUN; cur <= CENTER; tgt <= CENTER, or req if update=1 (done pulses).
  - RUN, enable=0: -> IDLE; cur, tgt <= CENTER; update ignored, no done.
  - RUN, enable=1: if update=1, tgt <= req and done pulses. Ramp: cur moves toward old tgt by min(RAMP_STEP, |tgt-cur|). A newly captured tgt first affects the ramp at the next boundary.
  - RAMP_STEP == 0: cur <= new tgt in the same edge (capture or current).
- Off-boundary, pwm_update is ignored, and pwm_done is 0 in every non-boundary-following cycle.
- pwm_signal_i (registered) <= (state RUN) && (cnt < cur), using pre-edge values. IDLE channels output 0.
- pwm_settled_i = RUN && cur == tgt (registered, updates with state).
- Channels are fully independent; simultaneous updates on any set of channels are all captured at the same boundary.

## Timing
- Reset (sync, highest priority): cnt=0; all channels IDLE; cur=tgt=CENTER; pwm_signal=0, pwm_done=0, pwm_settled=0. Reset mid-frame aborts the pulse on the next edge.
- pwm_signal lags cnt by 1 cycle. In RUN, each frame is high for exactly cur cycles, starting the cycle after cnt==0.
- Frame edge where the channel enters RUN: the first high pulse begins 1 cycle after that boundary edge (cnt==1 compare reflected at cycle 2 onward; cnt==0 compare used old state = IDLE → low that cycle). The first frame is therefore cur-1 cycles long.
- pwm_done is high for exactly the one cycle after the capturing boundary edge.
- Update-to-applied latency: 1 frame with RAMP_STEP=0. Otherwise ceil(|Δ|/RAMP_STEP) + 1 frames.
- Disable takes effect at the next boundary. The current frame's pulse completes normally.

## Test plan
- Reset then ch0 enable=1 only -> ch0 goes RUN at first boundary, high 635 cycles/frame after; ch1-3 stay 0; settled[0]=1.
- RAMP_STEP=0, ch1 enable, update ratio=200 dir=1 at boundary -> done[1] one cycle, next frame high 835 cycles; dir=0 -> 435 cycles.
- RAMP_STEP=4, RUN at 635, update ratio=10 dir=1 -> following frames 635,639,643,645; settled low until 645, then high.
- All 4 channels update at the same boundary with ratios 0/255/128/1 mixed dirs -> four done pulses same cycle, high times 635/890/507/636 (RAMP_STEP=0).
- Disable ch2 mid-frame -> current pulse finishes, low from the boundary on, update ignored (no done); re-enable restarts at 635.
- Assert reset mid-pulse -> pwm_signal, done, settled 0 next edge; cnt restarts at 0; all channels IDLE.
